// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
// Module   : piso_tx
// Purpose  : Transmitting end of a framed serial link. A parallel word is
//            accepted on a valid/ready handshake and sent MSB first as
//            START(0), WIDTH data bits, optional even-parity bit, STOP(1).
//            Every bit is held on the line for CYCLES_PER_BIT clocks.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   WIDTH          - data word width in bits (2..32)
//   CYCLES_PER_BIT - clocks each serial bit is held (1..256)
// Ports:
//   clk      in   clock, rising edge
//   clear    in   asynchronous active-high reset
//   in_data  in   parallel word to transmit
//   in_valid in   in_data holds a word to send
//   in_ready out  block can accept a word this cycle
//   sout     out  registered serial line, idles at 1
//   busy     out  a frame is in progress
//   done     out  one-cycle pulse as the block returns to idle
// Build option:
//   PISO_TX_PARITY_EN - when defined, an even-parity bit (XOR of the data
//                       bits) is sent between the data bits and STOP.
// ============================================================================
module piso_tx #(
    parameter int WIDTH          = 8,
    parameter int CYCLES_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam int BW = $clog2(WIDTH);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(CYCLES_PER_BIT - 1);
    localparam logic [BW-1:0] C_BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
`ifdef PISO_TX_PARITY_EN
        ,
        S_PARITY = 3'd3
`endif
    } state_t;

    state_t           r_state, w_state_next;
    logic [CW-1:0]    r_cnt,   w_cnt_next;
    logic [BW-1:0]    r_bit,   w_bit_next;
    logic [WIDTH-1:0] r_shreg, w_shreg_next;
    logic             r_sout,  w_sout_next;
    logic             r_done,  w_done_next;
    logic             w_bit_end;
    logic             w_accept;
`ifdef PISO_TX_PARITY_EN
    logic             r_parity, w_parity_next;
`endif

    assign in_ready  = (r_state == S_IDLE) && !clear;
    assign w_accept  = in_valid && in_ready;
    assign w_bit_end = (r_cnt == C_CNT_LAST);
    assign busy      = (r_state != S_IDLE);
    assign sout      = r_sout;
    assign done      = r_done;

    // Next-state and next-output logic. sout is computed one cycle ahead so
    // that the registered line changes on the same edge as the state.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = w_bit_end ? '0 : r_cnt + 1'b1;
        w_bit_next   = r_bit;
        w_shreg_next = r_shreg;
        w_sout_next  = r_sout;
        w_done_next  = 1'b0;
`ifdef PISO_TX_PARITY_EN
        w_parity_next = r_parity;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_next  = '0;
                w_sout_next = 1'b1;
                if (w_accept) begin
                    w_state_next = S_START;
                    w_shreg_next = in_data;
                    w_bit_next   = '0;
                    w_sout_next  = 1'b0;
`ifdef PISO_TX_PARITY_EN
                    w_parity_next = ^in_data;
`endif
                end
            end
            S_START: begin
                w_sout_next = 1'b0;
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                    w_bit_next   = '0;
                    w_sout_next  = r_shreg[WIDTH-1];
                end
            end
            S_DATA: begin
                w_sout_next = r_shreg[WIDTH-1];
                if (w_bit_end) begin
                    if (r_bit == C_BIT_LAST) begin
`ifdef PISO_TX_PARITY_EN
                        w_state_next = S_PARITY;
                        w_sout_next  = r_parity;
`else
                        w_state_next = S_STOP;
                        w_sout_next  = 1'b1;
`endif
                    end else begin
                        // The bit after the shift is the current second MSB.
                        w_shreg_next = {r_shreg[WIDTH-2:0], 1'b0};
                        w_bit_next   = r_bit + 1'b1;
                        w_sout_next  = r_shreg[WIDTH-2];
                    end
                end
            end
`ifdef PISO_TX_PARITY_EN
            S_PARITY: begin
                w_sout_next = r_parity;
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                    w_sout_next  = 1'b1;
                end
            end
`endif
            S_STOP: begin
                w_sout_next = 1'b1;
                if (w_bit_end) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
                w_sout_next  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
            r_sout  <= 1'b1;
            r_done  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_shreg <= w_shreg_next;
            r_sout  <= w_sout_next;
            r_done  <= w_done_next;
`ifdef PISO_TX_PARITY_EN
            r_parity <= w_parity_next;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_tx
// Purpose  : Self-checking bench for piso_tx (WIDTH=8, CYCLES_PER_BIT=4).
//            Expected line levels come from a frame model: a list of bit
//            slots (start, data MSB first, optional parity, stop), each held
//            CYCLES_PER_BIT clocks after the accepting edge.
// Revision : 1.0 - initial release
// Ports    : none (top-level bench)
// Build option: PISO_TX_PARITY_EN selects the parity frame format.
// ============================================================================
module tb_piso_tx;

    localparam int W   = 8;
    localparam int CPB = 4;
`ifdef PISO_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int SLOTS  = W + 2 + P;
    localparam int FRAME  = SLOTS * CPB;
    localparam int PERIOD = FRAME + 1;

    logic         clk = 1'b0;
    logic         clear;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         sout;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    piso_tx #(.WIDTH(W), .CYCLES_PER_BIT(CPB)) dut (
        .clk      (clk),
        .clear    (clear),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sout     (sout),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line level of bit slot idx for word w.
    function automatic logic slot_bit(input logic [W-1:0] w, input int idx);
        logic [W-1:0] t;
        t = w;
        if (idx == 0) return 1'b0;
        if (idx <= W) return t[W - idx];
        if (P == 1 && idx == W + 1) return ^t;
        return 1'b1;
    endfunction

    // Sends one word. Entered #1 after an edge with the block idle.
    // hold     : keep in_valid high with nxt on in_data (back-to-back)
    // inject_at: cycle index at which to pulse in_valid with 0xFF (-1 none)
    // abort_at : cycle index at which to pulse clear (-1 none)
    task automatic run_frame(input logic [W-1:0] w, input bit hold,
                             input logic [W-1:0] nxt, input int inject_at,
                             input int abort_at, output int acc_cyc);
        chk("ready_before_accept", in_ready, 1);
        in_data  = w;
        in_valid = 1'b1;
        step();
        acc_cyc = cyc;
        if (hold) begin
            in_data = nxt;
        end else begin
            in_valid = 1'b0;
            in_data  = W'($urandom);
        end
        for (int k = 0; k < FRAME; k++) begin
            if (k == inject_at) begin
                in_valid = 1'b1;
                in_data  = '1;
            end else if (inject_at >= 0 && k == inject_at + 1) begin
                in_valid = 1'b0;
                in_data  = W'($urandom);
            end
            if (k == abort_at) begin
                #2 clear = 1'b1;
                #1;
                chk("abort_sout", sout, 1);
                chk("abort_busy", busy, 0);
                chk("abort_ready", in_ready, 0);
                chk("abort_done", done, 0);
                step();
                chk("abort_hold_sout", sout, 1);
                chk("abort_hold_ready", in_ready, 0);
                #2 clear = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    step();
                    chk("post_abort_done", done, 0);
                    chk("post_abort_busy", busy, 0);
                    chk("post_abort_sout", sout, 1);
                end
                return;
            end
            chk("frame_sout", sout, slot_bit(w, k / CPB));
            chk("frame_busy", busy, 1);
            chk("frame_done", done, 0);
            step();
        end
        chk("end_sout", sout, 1);
        chk("end_busy", busy, 0);
        chk("end_done", done, 1);
        chk("end_ready", in_ready, 1);
        if (!hold) begin
            step();
            chk("idle_done_low", done, 0);
            chk("idle_busy", busy, 0);
            chk("idle_sout", sout, 1);
        end
    endtask

    initial begin
        int a1, a2, dummy;
        logic [W-1:0] rw;

        // Reset and idle behaviour.
        clear    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        #1;
        chk("reset_sout", sout, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ready", in_ready, 0);
        step();
        step();
        #2 clear = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("idle_sout", sout, 1);
            chk("idle_busy", busy, 0);
            chk("idle_ready", in_ready, 1);
            chk("idle_done", done, 0);
        end

        // Single frame 0xA5.
        run_frame(8'hA5, 1'b0, 8'h00, -1, -1, dummy);

        // Parity-sensitive frame.
        run_frame(8'h07, 1'b0, 8'h00, -1, -1, dummy);

        // Back-to-back with in_valid held high.
        run_frame(8'h3C, 1'b1, 8'hC3, -1, -1, a1);
        run_frame(8'hC3, 1'b0, 8'h00, -1, -1, a2);
        chk("b2b_period", a2 - a1, PERIOD);

        // in_valid with 0xFF during data of a 0x00 frame is ignored.
        run_frame(8'h00, 1'b0, 8'h00, 3 * CPB + 1, -1, dummy);

        // Clear during data bit 3 of 0x5A, then a clean 0x81 frame.
        run_frame(8'h5A, 1'b0, 8'h00, -1, 4 * CPB + 1, dummy);
        run_frame(8'h81, 1'b0, 8'h00, -1, -1, dummy);

        // Random words with random idle gaps.
        for (int i = 0; i < 10; i++) begin
            rw = W'($urandom);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
            run_frame(rw, 1'b0, 8'h00, -1, -1, dummy);
        end

        // Random back-to-back pair.
        rw = W'($urandom);
        run_frame(rw, 1'b1, ~rw, -1, -1, a1);
        run_frame(~rw, 1'b0, 8'h00, -1, -1, a2);
        chk("b2b_rand_period", a2 - a1, PERIOD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter: WIDTH, default 8, data word width in bits (legal range 2..32).
REQ-002 Parameter: CYCLES_PER_BIT, default 4, clock cycles each serial bit is held on the line (legal range 1..256).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: clear  input  1  reset, asynchronous, active-high.
REQ-005 Port: in_data  input  WIDTH  parallel word to transmit.
REQ-006 Port: in_valid  input  1  in_data holds a word to send.
REQ-007 Port: in_ready  output  1  block can accept a word this cycle.
REQ-008 Port: sout  output  1  serial line output; idle level 1.
REQ-009 Port: busy  output  1  a frame is in progress.
REQ-010 Port: done  output  1  one-cycle pulse when a frame completes.

Function
REQ-011 The block SHALL be the transmitting end of the serial link: parallel-in, framed serial-out, MSB first (left shift).
REQ-012 States SHALL be IDLE, START, DATA, PARITY (only with PISO_TX_PARITY_EN), STOP.
REQ-013 in_ready SHALL be 1 exactly when state is IDLE and clear is 0.
REQ-014 A word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in_data is captured into an internal shift register on that edge, and the state becomes START.
REQ-015 in_valid while not IDLE SHALL be ignored, with no capture and no effect on the frame in progress.
REQ-016 Changes on in_data after acceptance SHALL NOT affect the frame.
REQ-017 sout SHALL be registered: 1 in IDLE and STOP, 0 in START, the current shift-register MSB in DATA, the parity bit in PARITY.
REQ-018 Each of START, every DATA bit, PARITY, and STOP SHALL last exactly CYCLES_PER_BIT cycles, timed by a bit-cycle counter that restarts at every bit boundary.
REQ-019 DATA SHALL emit exactly WIDTH bits: shift left by one at each bit boundary, with a bit counter from 0 to WIDTH-1; after the last bit, go to PARITY if enabled, else STOP.
REQ-020 After STOP the state SHALL return to IDLE, and done SHALL be 1 for the single cycle in which the state becomes IDLE.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 Acceptance-to-acceptance period with in_valid held at 1 SHALL be (WIDTH+2+P)*CYCLES_PER_BIT+1 cycles, where P=1 if parity is enabled, else 0; the extra cycle is the mandatory IDLE cycle.
REQ-023 The first START cycle SHALL appear on sout in the cycle immediately after the accepting edge (latency 1).

Reset
REQ-024 When clear=1, regardless of clk, the block SHALL set state=IDLE, sout=1, busy=0, done=0, and all counters and the shift register to 0.
REQ-025 A clear asserted mid-frame SHALL abort the frame, with no done pulse and no resumption; in_ready SHALL be 0 while clear=1.
REQ-026 After clear deasserts, the first acceptance SHALL be possible on the first rising edge with in_valid=1.

Configuration
REQ-027 Macro PISO_TX_PARITY_EN: when defined, a PARITY bit SHALL be sent between DATA and STOP, equal to the XOR of all WIDTH data bits (even parity), computed at acceptance.
REQ-028 Without PISO_TX_PARITY_EN, the PARITY state and the parity logic SHALL be absent, and DATA SHALL go directly to STOP.

Verification (WIDTH=8, CYCLES_PER_BIT=4)
REQ-029 Reset idle: clear=1 then 0, no in_valid -> sout=1, busy=0, in_ready=1, done=0 for 50 cycles.
REQ-030 Single frame, no macro: 0xA5 accepted -> sout=0,1,0,1,0,0,1,0,1,1, each held 4 cycles; done pulses at cycle 41 after acceptance.
REQ-031 Parity frame, macro defined: 0x07 -> start 0, data 0,0,0,0,0,1,1,1, parity 1, stop 1; 0xA5 gives parity 0.
REQ-032 Back-to-back: in_valid held at 1 with words 0x3C then 0xC3 -> second acceptance exactly 41 cycles after the first, and both frames are bit-exact.
REQ-033 Ignore-while-busy: in_valid pulsed with 0xFF during DATA of a 0x00 frame -> sout data bits all 0, and 0xFF is never transmitted.
REQ-034 Reset mid-frame: clear pulsed during data bit 3 of 0x5A -> sout=1 immediately, no done pulse; the next accepted 0x81 frame is correct.
